// File: rtl/calc_mem_arbiter.sv
// calc_mem_arbiter: round-robin arbiter sharing a write-port/read-port 64-bit SRAM pair between two requesters
// Ports: clk_i/rst_i (async active-low) clock and reset; host_lock_i gives requester 1 exclusive access;
// wvalid_i/waddr_i/wdata_i/wready_o write channel; rvalid_i/raddr_i/rready_o read channel;
// rresp_valid_o/rresp_data_o read responses; write_o/w_addr_o/w_data_o SRAM port 0;
// read_o/r_addr_o/r_data_i SRAM port 1 (data one cycle after read_o).
module calc_mem_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  host_lock_i,
  input  logic [1:0]            wvalid_i,
  input  logic [2*ADDR_W-1:0]   waddr_i,
  input  logic [2*DATA_W-1:0]   wdata_i,
  output logic [1:0]            wready_o,
  input  logic [1:0]            rvalid_i,
  input  logic [2*ADDR_W-1:0]   raddr_i,
  output logic [1:0]            rready_o,
  output logic [1:0]            rresp_valid_o,
  output logic [DATA_W-1:0]     rresp_data_o,
  output logic                  write_o,
  output logic [ADDR_W-1:0]     w_addr_o,
  output logic [DATA_W-1:0]     w_data_o,
  output logic                  read_o,
  output logic [ADDR_W-1:0]     r_addr_o,
  input  logic [DATA_W-1:0]     r_data_i
);
  logic              last_w, last_r, rtag_v, rtag_id, hazard;
  logic [1:0]        el_w, el_r, gw, gr;
  logic [ADDR_W-1:0] ra;
  always_comb begin
    el_w = rst_i ? wvalid_i & {1'b1, ~host_lock_i} : 2'b00;
    el_r = rst_i ? rvalid_i & {1'b1, ~host_lock_i} : 2'b00;
    gw = {el_w[1] & (~el_w[0] | ~last_w), el_w[0] & (~el_w[1] | last_w)};
    gr = {el_r[1] & (~el_r[0] | ~last_r), el_r[0] & (~el_r[1] | last_r)};
    w_addr_o = gw[1] ? waddr_i[ADDR_W +: ADDR_W] : gw[0] ? waddr_i[0 +: ADDR_W] : '0;
    w_data_o = gw[1] ? wdata_i[DATA_W +: DATA_W] : gw[0] ? wdata_i[0 +: DATA_W] : '0;
    ra = gr[1] ? raddr_i[ADDR_W +: ADDR_W] : gr[0] ? raddr_i[0 +: ADDR_W] : '0;
    // write-first: a same-address read waits a cycle so it returns the new data
    hazard = (|gw) && (|gr) && (w_addr_o == ra);
    wready_o = gw;
    write_o = |gw;
    rready_o = hazard ? 2'b00 : gr;
    read_o = |rready_o;
    r_addr_o = hazard ? '0 : ra;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_w  <= 1'b1;
      last_r  <= 1'b1;
      rtag_v  <= 1'b0;
      rtag_id <= 1'b0;
    end else begin
      if (write_o) last_w <= gw[1];
      if (read_o) last_r <= rready_o[1];
      rtag_v  <= read_o;
      rtag_id <= rready_o[1];
    end
  end
  assign rresp_valid_o = {rtag_v & rtag_id, rtag_v & ~rtag_id};
  assign rresp_data_o  = r_data_i;
endmodule

// File: tb/tb_calc_mem_arbiter.sv
// tb_calc_mem_arbiter: table-driven self-checking bench for calc_mem_arbiter
module tb_calc_mem_arbiter;
  localparam logic [63:0] da = 64'hA0;
  localparam logic [63:0] db = 64'hB0;
  localparam logic [63:0] dk = 64'h0123456789ABCDEF;
  localparam logic [63:0] dc = 64'hCAFE00000000000A;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lock = 1'b0;
  logic [1:0]  wvalid = 2'b00, rvalid = 2'b00;
  logic [17:0] waddr = '0, raddr = '0;
  logic [127:0] wdata = '0;
  logic [1:0]  wready, rready, rresp_valid;
  logic [63:0] rresp_data, w_data, r_data;
  logic        write, read;
  logic [8:0]  w_addr, r_addr;
  logic [63:0] mem [512];
  int          total = 0;
  int          passed = 0;
  typedef struct {
    logic lock; logic [1:0] wv; logic [8:0] wa0, wa1; logic [63:0] wd0, wd1;
    logic [1:0] rv; logic [8:0] ra0, ra1;
    logic [1:0] ew; logic [8:0] ewa; logic [63:0] ewd;
    logic [1:0] er; logic [8:0] era; logic [1:0] erv; logic [63:0] erd;
  } vec_t;
  vec_t v [27];

  calc_mem_arbiter dut (
    .clk_i(clk), .rst_i(rst), .host_lock_i(lock),
    .wvalid_i(wvalid), .waddr_i(waddr), .wdata_i(wdata), .wready_o(wready),
    .rvalid_i(rvalid), .raddr_i(raddr), .rready_o(rready),
    .rresp_valid_o(rresp_valid), .rresp_data_o(rresp_data),
    .write_o(write), .w_addr_o(w_addr), .w_data_o(w_data),
    .read_o(read), .r_addr_o(r_addr), .r_data_i(r_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write) mem[w_addr] <= w_data;
    if (read) r_data <= mem[r_addr];
  end

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", n, act, exp);
    else passed++;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 64'h1000 + 64'(i);
    r_data = '0;
    v[0]  = '{0, 2'b11, 9'h010, 9'h020, da, db, 2'b00, 9'h0, 9'h0, 2'b01, 9'h010, da, 2'b00, 9'h0, 2'b00, 64'h0};
    v[1]  = '{0, 2'b11, 9'h010, 9'h020, da, db, 2'b00, 9'h0, 9'h0, 2'b10, 9'h020, db, 2'b00, 9'h0, 2'b00, 64'h0};
    v[2]  = v[0];
    v[3]  = v[1];
    v[4]  = '{0, 2'b10, 9'h0, 9'h005, da, dk, 2'b00, 9'h0, 9'h0, 2'b10, 9'h005, dk, 2'b00, 9'h0, 2'b00, 64'h0};
    v[5]  = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b01, 9'h005, 9'h0, 2'b00, 9'h0, 64'h0, 2'b01, 9'h005, 2'b00, 64'h0};
    v[6]  = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b00, 9'h0, 9'h0, 2'b00, 9'h0, 64'h0, 2'b00, 9'h0, 2'b01, dk};
    v[7]  = '{0, 2'b01, 9'h00A, 9'h0, dc, db, 2'b10, 9'h0, 9'h00A, 2'b01, 9'h00A, dc, 2'b00, 9'h0, 2'b00, 64'h0};
    v[8]  = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b10, 9'h0, 9'h00A, 2'b00, 9'h0, 64'h0, 2'b10, 9'h00A, 2'b00, 64'h0};
    v[9]  = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b00, 9'h0, 9'h0, 2'b00, 9'h0, 64'h0, 2'b00, 9'h0, 2'b10, dc};
    v[10] = '{1, 2'b00, 9'h0, 9'h0, da, db, 2'b11, 9'h001, 9'h002, 2'b00, 9'h0, 64'h0, 2'b10, 9'h002, 2'b00, 64'h0};
    v[11] = '{1, 2'b00, 9'h0, 9'h0, da, db, 2'b11, 9'h001, 9'h002, 2'b00, 9'h0, 64'h0, 2'b10, 9'h002, 2'b10, 64'h1002};
    v[12] = v[11];
    v[13] = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b11, 9'h001, 9'h002, 2'b00, 9'h0, 64'h0, 2'b01, 9'h001, 2'b10, 64'h1002};
    v[14] = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b00, 9'h0, 9'h0, 2'b00, 9'h0, 64'h0, 2'b00, 9'h0, 2'b01, 64'h1001};
    v[15] = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b01, 9'h001, 9'h0, 2'b00, 9'h0, 64'h0, 2'b01, 9'h001, 2'b00, 64'h0};
    v[16] = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b10, 9'h0, 9'h002, 2'b00, 9'h0, 64'h0, 2'b10, 9'h002, 2'b01, 64'h1001};
    v[17] = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b01, 9'h003, 9'h0, 2'b00, 9'h0, 64'h0, 2'b01, 9'h003, 2'b10, 64'h1002};
    v[18] = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b10, 9'h0, 9'h004, 2'b00, 9'h0, 64'h0, 2'b10, 9'h004, 2'b01, 64'h1003};
    v[19] = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b00, 9'h0, 9'h0, 2'b00, 9'h0, 64'h0, 2'b00, 9'h0, 2'b10, 64'h1004};
    v[20] = '{0, 2'b11, 9'h030, 9'h031, da, db, 2'b11, 9'h032, 9'h033, 2'b10, 9'h031, db, 2'b01, 9'h032, 2'b00, 64'h0};
    v[21] = '{1, 2'b11, 9'h030, 9'h031, da, db, 2'b00, 9'h0, 9'h0, 2'b10, 9'h031, db, 2'b00, 9'h0, 2'b01, 64'h1032};
    v[22] = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b01, 9'h005, 9'h0, 2'b00, 9'h0, 64'h0, 2'b01, 9'h005, 2'b00, 64'h0};
    v[23] = '{1, 2'b00, 9'h0, 9'h0, da, db, 2'b00, 9'h0, 9'h0, 2'b00, 9'h0, 64'h0, 2'b00, 9'h0, 2'b01, dk};
    v[24] = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b11, 9'h010, 9'h020, 2'b00, 9'h0, 64'h0, 2'b10, 9'h020, 2'b00, 64'h0};
    v[25] = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b01, 9'h010, 9'h0, 2'b00, 9'h0, 64'h0, 2'b01, 9'h010, 2'b10, db};
    v[26] = '{0, 2'b00, 9'h0, 9'h0, da, db, 2'b00, 9'h0, 9'h0, 2'b00, 9'h0, 64'h0, 2'b00, 9'h0, 2'b01, da};

    wvalid = 2'b11; rvalid = 2'b11; waddr = {9'h020, 9'h010}; raddr = {9'h002, 9'h001};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset wready", 64'(wready), 64'h0);
    chk("reset rready", 64'(rready), 64'h0);
    chk("reset write_o", 64'(write), 64'h0);
    chk("reset read_o", 64'(read), 64'h0);
    chk("reset rresp_valid", 64'(rresp_valid), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 27; i++) begin
      lock = v[i].lock; wvalid = v[i].wv; waddr = {v[i].wa1, v[i].wa0}; wdata = {v[i].wd1, v[i].wd0};
      rvalid = v[i].rv; raddr = {v[i].ra1, v[i].ra0};
      @(negedge clk);
      chk($sformatf("v%0d wready", i), 64'(wready), 64'(v[i].ew));
      chk($sformatf("v%0d w_addr", i), 64'(w_addr), 64'(v[i].ewa));
      chk($sformatf("v%0d w_data", i), w_data, v[i].ewd);
      chk($sformatf("v%0d write_o", i), 64'(write), 64'(|v[i].ew));
      chk($sformatf("v%0d rready", i), 64'(rready), 64'(v[i].er));
      chk($sformatf("v%0d r_addr", i), 64'(r_addr), 64'(v[i].era));
      chk($sformatf("v%0d read_o", i), 64'(read), 64'(|v[i].er));
      chk($sformatf("v%0d rresp_valid", i), 64'(rresp_valid), 64'(v[i].erv));
      if (v[i].erv != 2'b00) chk($sformatf("v%0d rresp_data", i), rresp_data, v[i].erd);
      @(posedge clk); #1;
    end

    lock = 1'b0; wvalid = 2'b00; rvalid = 2'b01; raddr = {9'h0, 9'h001};
    @(negedge clk);
    chk("midreset grant", 64'(rready), 64'h1);
    @(posedge clk); #1;
    rst = 1'b0; rvalid = 2'b00; wvalid = 2'b11; waddr = {9'h041, 9'h040};
    @(negedge clk);
    chk("midreset rresp", 64'(rresp_valid), 64'h0);
    chk("midreset wready gated", 64'(wready), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post reset rresp", 64'(rresp_valid), 64'h0);
    chk("post reset first wready", 64'(wready), 64'h1);
    chk("post reset w_addr", 64'(w_addr), 64'h040);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post reset rresp late", 64'(rresp_valid), 64'h0);
    chk("post reset second wready", 64'(wready), 64'h2);
    @(posedge clk); #1;
    wvalid = 2'b00;
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/calc_mem_arbiter.md
Name: calc_mem_arbiter

Overview:
- Shares the calculator's 64-bit memory (two 32x512 SRAM macros: port 0 write-only, port 1 read-only) between two requesters: requester 0 is the calculator controller and requester 1 is the host loader/readback path.
- Write and read channels are arbitrated independently with round-robin fairness.
- Read data is routed back to the requester that issued the read, using the 1-cycle SRAM read latency.
- Sits between the requesters and the SRAM pair in the calculator top level.

Parameters:
- ADDR_W, 9, word address width (512 entries).
- DATA_W, 64, word width ({upper macro, lower macro}).

Ports:
- clk_i  in  1  clock; also clocks both SRAM macros.
- rst_i  in  1  asynchronous, active-low reset.
- host_lock_i  in  1  when 1, requester 1 has exclusive access to both channels.
- wvalid_i  in  2  write request per requester (bit k = requester k).
- waddr_i  in  2*ADDR_W  write address, requester k at bits [k*ADDR_W +: ADDR_W].
- wdata_i  in  2*DATA_W  write data, packed the same way.
- wready_o  out  2  write accepted this cycle.
- rvalid_i  in  2  read request per requester.
- raddr_i  in  2*ADDR_W  read address, packed.
- rready_o  out  2  read accepted this cycle.
- rresp_valid_o  out  2  read data valid for requester k.
- rresp_data_o  out  DATA_W  read data, shared bus.
- write_o  out  1  SRAM port-0 enable, active-high (top level inverts it for csb0/web0).
- w_addr_o  out  ADDR_W  SRAM write address.
- w_data_o  out  DATA_W  SRAM write data.
- read_o  out  1  SRAM port-1 enable, active-high (top level inverts it for csb1).
- r_addr_o  out  ADDR_W  SRAM read address.
- r_data_i  in  DATA_W  SRAM read data, valid 1 cycle after read_o.

Behaviour:
- Handshake is valid/ready. A request transfers in a cycle where valid and ready are both 1.
- A requester must hold valid, addr and data stable until ready. Dropping valid before ready is allowed; nothing is issued.
- Grants are combinational from the current-cycle requests and registered pointers:
  - wready_o and write_o are asserted in the same cycle as the grant, with w_addr_o/w_data_o muxed from the winner.
  - The same applies to the read channel (rready_o, read_o, r_addr_o).
- Eligibility: requester 0 is ineligible on both channels while host_lock_i=1. Requester 1 is always eligible.
- Round-robin, per channel:
  - 1-bit pointer last_w / last_r holds the most recently granted requester.
  - If both requesters are eligible and requesting, the requester != last grants.
  - A single eligible requester grants regardless of the pointer.
  - The pointer updates only on an actual grant.
- Write-first hazard: if a read grant and a write grant in the same cycle target the same address, the read is stalled.
  - rready_o=0 and read_o=0 for that cycle.
  - last_r does not change.
  - The write proceeds as normal.
- Read response:
  - Registered tag rtag_q (valid bit + requester id) is captured on each read grant.
  - In the next cycle, rresp_valid_o[id]=1 for exactly one cycle and rresp_data_o = r_data_i.
  - Back-to-back reads are supported: one read per cycle, responses in order.
  - No backpressure on responses; requesters must always accept them.
- Unselected outputs:
  - w_addr_o/w_data_o/r_addr_o = 0 when their channel has no grant.
  - rresp_data_o = r_data_i at all times; it is meaningful only with rresp_valid_o.
- Reset (rst_i=0, asynchronous):
  - last_w=last_r=1, so requester 0 wins the first contention.
  - rtag_q cleared, rresp_valid_o=0.
  - All grant outputs are gated to 0 while in reset.
- Reset mid-read: a response pending from the cycle before reset is discarded (no rresp_valid_o after release).
- Asserting host_lock_i while a requester-0 read response is pending still delivers that response. Lock affects grants only.
- At most one write and one read issue per cycle. write_o and read_o are never asserted without a matching ready.

Test Plan:
- Reset release, both wvalid_i=2'b11 (addr 0x010 / 0x020) for 4 cycles -> wready_o sequence 01,10,01,10; writes land at 0x010, 0x020, 0x010, 0x020.
- Requester 1 writes 0x0123456789ABCDEF to 0x005, then requester 0 reads 0x005 -> rresp_valid_o=2'b01 exactly one cycle after rready_o[0]; rresp_data_o=0x0123456789ABCDEF; rresp_valid_o[1] stays 0.
- Same cycle: requester 0 writes 0x00A, requester 1 reads 0x00A -> rready_o[1]=0, read_o=0 that cycle; next cycle the read is granted and returns the new data.
- host_lock_i=1 with both requesters reading for 3 cycles -> rready_o=2'b10 every cycle, requester 0 starved; drop lock -> requester 0 granted next cycle.
- Back-to-back reads of 0x001..0x004 by alternating requesters -> four consecutive single-cycle responses, in order, with correct ids.
- Assert rst_i=0 the cycle after a read grant -> no rresp_valid_o after release; first contended write goes to requester 0.
